// File: rtl/seq_shifter_pkg.sv
// Shared mode and state definitions for the sequential shifter.
package seq_shifter_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/seq_shifter_step.sv
// One-bit shift step: next word plus the bit that leaves the word.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] word,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] word_nxt,
  output logic             bit_out
);

  always_comb begin
    word_nxt = word;
    bit_out  = 1'b0;
    case (mode)
      SH_LSL: begin
        word_nxt = {word[WIDTH-2:0], 1'b0};
        bit_out  = word[WIDTH-1];
      end
      SH_LSR: begin
        word_nxt = {1'b0, word[WIDTH-1:1]};
        bit_out  = word[0];
      end
      SH_ASR: begin
        word_nxt = {word[WIDTH-1], word[WIDTH-1:1]};
        bit_out  = word[0];
      end
      SH_ROR: begin
        word_nxt = {word[0], word[WIDTH-1:1]};
        bit_out  = word[0];
      end
      default: begin
        word_nxt = word;
        bit_out  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter, one bit per clock, valid/ready on both sides.
// Optional carry output enabled by SEQ_SHIFTER_CARRY_EN.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       shift,
  input  logic [AMT_W-1:0] amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sout
`ifdef SEQ_SHIFTER_CARRY_EN
  ,
  output logic             carry
`endif
);

  state_t           state, state_nxt;
  logic [AMT_W-1:0] count;
  logic [1:0]       mode;
  logic [WIDTH-1:0] step_word;
  logic             accept, do_step;
`ifdef SEQ_SHIFTER_CARRY_EN
  logic             step_bit;
`else
  logic             step_bit_unused;
`endif

  shift_step #(.WIDTH(WIDTH)) u_step (
    .word     (sout),
    .mode     (mode),
    .word_nxt (step_word),
`ifdef SEQ_SHIFTER_CARRY_EN
    .bit_out  (step_bit)
`else
    .bit_out  (step_bit_unused)
`endif
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    do_step   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (count == '0) state_nxt = ST_DONE;
        else             do_step   = 1'b1;
      end
      ST_DONE: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sout  <= '0;
      count <= '0;
      mode  <= SH_LSL;
    end else if (accept) begin
      sout  <= in;
      mode  <= shift;
      count <= amt;
    end else if (do_step) begin
      sout  <= step_word;
      count <= count - 1'b1;
    end
  end

`ifdef SEQ_SHIFTER_CARRY_EN
  // Cleared on accept so a zero-step request reports no carry.
  always_ff @(posedge clk) begin
    if (!reset_n)     carry <= 1'b0;
    else if (accept)  carry <= 1'b0;
    else if (do_step) carry <= step_bit;
  end
`endif

endmodule

// File: tb/tb_seq_shifter.sv
// Table-driven and scoreboard bench for seq_shifter (16- and 32-bit builds).
module tb_seq_shifter;

  localparam logic [1:0] LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROR = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, out_valid, out_ready, carry;
  logic [15:0] din, sout;
  logic [1:0]  shift;
  logic [3:0]  amt;

  logic        in_valid32, in_ready32, out_valid32, out_ready32, carry32;
  logic [31:0] din32, sout32;
  logic [1:0]  shift32;
  logic [4:0]  amt32;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in(din), .shift(shift), .amt(amt), .out_valid(out_valid),
    .out_ready(out_ready), .sout(sout)
`ifdef SEQ_SHIFTER_CARRY_EN
    , .carry(carry)
`endif
  );

  seq_shifter #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .in(din32), .shift(shift32), .amt(amt32), .out_valid(out_valid32),
    .out_ready(out_ready32), .sout(sout32)
`ifdef SEQ_SHIFTER_CARRY_EN
    , .carry(carry32)
`endif
  );

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] d;
    logic [3:0]  a;
    logic [15:0] es;
    logic        ec;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        c;
    int unsigned lat;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference built from whole-word shift operators, independent of stepping.
  task automatic model(input logic [1:0] m, input logic [15:0] d, input logic [3:0] a,
                       output logic [15:0] s, output logic c);
    logic signed [15:0] sd;
    int unsigned ai;
    sd = d;
    ai = a;
    case (m)
      LSL:     s = d << ai;
      LSR:     s = d >> ai;
      ASR:     s = sd >>> ai;
      default: s = (d >> ai) | (d << (16 - ai));
    endcase
    if (ai == 0)     c = 1'b0;
    else if (m == LSL) c = d[16 - ai];
    else             c = d[ai - 1];
  endtask

  task automatic wait_done(input string name, output int unsigned edges, output logic ok);
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk); edges++; #1;
    end
    ok = out_valid;
    if (!ok) chk({name, "/timeout"}, out_valid, 1);
  endtask

  task automatic run(input string name, input logic [1:0] m, input logic [15:0] d,
                     input logic [3:0] a, input logic [15:0] es, input logic ec);
    exp_t e;
    int unsigned edges;
    logic ok;
    e.s = es; e.c = ec; e.lat = a + 1;
    sbq.push_back(e);
    @(negedge clk);
    chk({name, "/in_ready"}, in_ready, 1);
    in_valid = 1'b1; din = d; shift = m; amt = a; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; din = 16'($urandom); shift = 2'($urandom);
    wait_done(name, edges, ok);
    e = sbq.pop_front();
    if (ok) begin
      chk({name, "/latency"}, edges, e.lat);
      chk({name, "/sout"}, sout, e.s);
`ifdef SEQ_SHIFTER_CARRY_EN
      chk({name, "/carry"}, carry, e.c);
`endif
      @(posedge clk); #1;
      chk({name, "/idle_after"}, in_ready, 1);
      chk({name, "/valid_after"}, out_valid, 0);
    end
    out_ready = 1'b0;
  endtask

  vec_t vt[$];

  initial begin
    exp_t e;
    int unsigned edges;
    logic ok;
    logic [15:0] held, ms;
    logic mc;

    vt.push_back('{LSL, 16'h0001, 4'd4,  16'h0010, 1'b0});
    vt.push_back('{ASR, 16'h8000, 4'd3,  16'hF000, 1'b0});
    vt.push_back('{LSR, 16'h8000, 4'd3,  16'h1000, 1'b0});
    vt.push_back('{ROR, 16'h0001, 4'd1,  16'h8000, 1'b1});
    vt.push_back('{LSL, 16'hA5A5, 4'd0,  16'hA5A5, 1'b0});
    vt.push_back('{LSR, 16'hA5A5, 4'd0,  16'hA5A5, 1'b0});
    vt.push_back('{ASR, 16'hA5A5, 4'd0,  16'hA5A5, 1'b0});
    vt.push_back('{ROR, 16'hA5A5, 4'd0,  16'hA5A5, 1'b0});
    vt.push_back('{ASR, 16'h8001, 4'd15, 16'hFFFF, 1'b0});
    vt.push_back('{ROR, 16'h1234, 4'd4,  16'h4123, 1'b0});

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0; shift = '0; amt = '0;
    in_valid32 = 1'b0; out_ready32 = 1'b0; din32 = '0; shift32 = '0; amt32 = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("reset/in_ready", in_ready, 1);
    chk("reset/out_valid", out_valid, 0);
    chk("reset/sout", sout, 0);
`ifdef SEQ_SHIFTER_CARRY_EN
    chk("reset/carry", carry, 0);
`endif

    foreach (vt[i]) run($sformatf("vec%0d", i), vt[i].mode, vt[i].d, vt[i].a, vt[i].es, vt[i].ec);

    for (int i = 0; i < 8; i++) begin
      logic [1:0] m; logic [15:0] d; logic [3:0] a;
      m = 2'($urandom); d = 16'($urandom); a = 4'($urandom);
      model(m, d, a, ms, mc);
      run($sformatf("rnd%0d", i), m, d, a, ms, mc);
    end

    // Back-pressure: result held in DONE while requests are refused.
    e.s = 16'h8000; e.c = 1'b1; e.lat = 16;
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b1; din = 16'hFFFF; shift = LSL; amt = 4'd15; out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_done("bp", edges, ok);
    e = sbq.pop_front();
    chk("bp/latency", edges, e.lat);
    chk("bp/sout", sout, e.s);
`ifdef SEQ_SHIFTER_CARRY_EN
    chk("bp/carry", carry, e.c);
`endif
    held = sout;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); in_valid = 1'b1; din = 16'h1234; amt = 4'd2;
      @(posedge clk); #1;
      chk("bp/out_valid_held", out_valid, 1);
      chk("bp/in_ready_low", in_ready, 0);
      chk("bp/sout_stable", sout, held);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp/release_idle", in_ready, 1);
    @(posedge clk); #1;
    chk("bp/no_stale_accept", in_ready, 1);
    out_ready = 1'b0;

    // Reset in the middle of a ROR amt=10 discards the result.
    @(negedge clk);
    in_valid = 1'b1; din = 16'h1234; shift = ROR; amt = 4'd10;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid/in_ready", in_ready, 1);
    chk("rst_mid/out_valid", out_valid, 0);
    chk("rst_mid/sout", sout, 0);
`ifdef SEQ_SHIFTER_CARRY_EN
    chk("rst_mid/carry", carry, 0);
`endif
    reset_n = 1'b1;
    run("rst_fresh", ROR, 16'h1234, 4'd10, 16'h8D04, 1'b1);

    // 32-bit instance: ASR of the sign bit over the full range.
    @(negedge clk);
    in_valid32 = 1'b1; din32 = 32'h8000_0000; shift32 = ASR; amt32 = 5'd31; out_ready32 = 1'b0;
    @(posedge clk); #1 in_valid32 = 1'b0;
    edges = 0;
    while (!out_valid32 && edges < 80) begin
      @(posedge clk); edges++; #1;
    end
    chk("w32/done", out_valid32, 1);
    chk("w32/latency", edges, 32);
    chk("w32/sout", sout32, 32'hFFFF_FFFF);
`ifdef SEQ_SHIFTER_CARRY_EN
    chk("w32/carry", carry32, 0);
`endif
    out_ready32 = 1'b1;
    @(posedge clk); #1;
    chk("w32/idle_after", in_ready32, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
